// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and text/BCD helpers for the status LCD driver.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h28;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] LINE1     = 8'h80;
  localparam logic [7:0] LINE2     = 8'hC0;
  localparam logic [7:0] INIT_NIB3 = 8'h30;
  localparam logic [7:0] INIT_NIB2 = 8'h20;

  // Fixed text templates; digit and state-name positions are overlaid by the mux.
  localparam logic [127:0] TXT_L1   = "LVL 000  TIME 00";
  localparam logic [127:0] TXT_L2   = "NUM 00      IDLE";
  localparam logic [31:0]  TXT_IDLE = "IDLE";
  localparam logic [31:0]  TXT_PLAY = "PLAY";
  localparam logic [31:0]  TXT_WIN  = "WIN ";
  localparam logic [31:0]  TXT_LOSE = "LOSE";

  typedef enum logic [3:0] {
    ST_PWR_WAIT, ST_INIT_A, ST_INIT_B, ST_INIT_C, ST_INIT_D, ST_CFG,
    ST_SNAP, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_DONE
  } lcd_state_e;

  typedef enum logic [2:0] {
    W_IDLE, W_SETUP, W_EN, W_HOLD, W_GAP, W_WAIT
  } wr_state_e;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = FUNC_SET;
      2'd1:    b = ENTRY;
      2'd2:    b = DISP_ON;
      default: b = CLEAR;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] text_char(input logic [127:0] t, input logic [3:0] pos);
    return t[8*(15-pos) +: 8];
  endfunction

  function automatic logic [7:0] state_char(input logic [1:0] st, input logic [1:0] k);
    logic [31:0] name;
    case (st)
      2'd0:    name = TXT_IDLE;
      2'd1:    name = TXT_PLAY;
      2'd2:    name = TXT_WIN;
      default: name = TXT_LOSE;
    endcase
    return name[8*(3-k) +: 8];
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Double-dabble; pos selects hundreds (2), tens (1) or units (0).
  function automatic logic [3:0] bcd_digit(input logic [7:0] bin, input logic [1:0] pos);
    logic [19:0] sh;
    logic [3:0]  r;
    sh = {12'd0, bin};
    for (int unsigned i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    case (pos)
      2'd2:    r = sh[19:16];
      2'd1:    r = sh[15:12];
      default: r = sh[11:8];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit bus write engine: setup, enable pulse, hold, nibble gap and
// post-write wait; done_o pulses for one cycle at the end of the wait.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_EN  = 12,
  parameter int unsigned T_NIB = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        rs_i,
  input  logic [7:0]  byte_i,
  input  logic        nibble_only_i,
  input  logic [31:0] wait_cycles_i,
  output logic        done_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic [3:0]  lcd_d_o
);

  wr_state_e   st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic [3:0]  lo_q, lo_d;
  logic [3:0]  d_q, d_d;
  logic        rs_q, rs_d;
  logic        nib_only_q, nib_only_d;
  logic        lower_q, lower_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= W_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      lo_q       <= '0;
      d_q        <= '0;
      rs_q       <= 1'b0;
      nib_only_q <= 1'b0;
      lower_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      lo_q       <= lo_d;
      d_q        <= d_d;
      rs_q       <= rs_d;
      nib_only_q <= nib_only_d;
      lower_q    <= lower_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    lo_d       = lo_q;
    d_d        = d_q;
    rs_d       = rs_q;
    nib_only_d = nib_only_q;
    lower_d    = lower_q;
    done_o     = 1'b0;
    case (st_q)
      W_IDLE: begin
        if (start_i) begin
          rs_d       = rs_i;
          d_d        = byte_i[7:4];
          lo_d       = byte_i[3:0];
          nib_only_d = nibble_only_i;
          wait_d     = wait_cycles_i;
          lower_d    = 1'b0;
          st_d       = W_SETUP;
        end
      end
      W_SETUP: begin
        cnt_d = '0;
        st_d  = W_EN;
      end
      W_EN: begin
        if (cnt_q == T_EN - 1) begin
          cnt_d = '0;
          st_d  = W_HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      W_HOLD: begin
        cnt_d = '0;
        st_d  = (!lower_q && !nib_only_q) ? W_GAP : W_WAIT;
      end
      W_GAP: begin
        if (cnt_q == T_NIB - 1) begin
          d_d     = lo_q;
          lower_d = 1'b1;
          st_d    = W_SETUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      W_WAIT: begin
        if (cnt_q == wait_q - 32'd1) begin
          done_o = 1'b1;
          st_d   = W_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: st_d = W_IDLE;
    endcase
  end

  assign lcd_e_o  = (st_q == W_EN);
  assign lcd_rs_o = rs_q;
  assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_status_display.sv
// 2x16 character LCD renderer for the number game: init sequence, then a
// continuous tear-free refresh of level, time left, target number and state.
module lcd_status_display
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_NIB   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] level,
  input  logic [0:1] state,
  input  logic [0:4] timeleft,
  input  logic [0:3] number,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [0:3] lcd_d,
  output logic       frame_done
);

  lcd_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        snap_en;

  logic [7:0]  lvl_q;
  logic [1:0]  st_q;
  logic [4:0]  tm_q;
  logic [3:0]  num_q;

  logic        wr_start, wr_rs, wr_nib, wr_done, is_write;
  logic [7:0]  wr_byte;
  logic [31:0] wr_wait;
  logic [3:0]  wr_d;
  logic [7:0]  ch;
  logic [3:0]  lv2, lv1, lv0, tm1, tm0, nm1, nm0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      lvl_q   <= '0;
      st_q    <= '0;
      tm_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (snap_en) begin
        lvl_q <= level;
        st_q  <= state;
        tm_q  <= timeleft;
        num_q <= number;
      end
    end
  end

  // Digits settle combinationally from the snapshot during SNAP/ADDR1,
  // well before the first digit byte is issued.
  assign lv2 = bcd_digit(lvl_q, 2'd2);
  assign lv1 = bcd_digit(lvl_q, 2'd1);
  assign lv0 = bcd_digit(lvl_q, 2'd0);
  assign tm1 = bcd_digit({3'b000, tm_q}, 2'd1);
  assign tm0 = bcd_digit({3'b000, tm_q}, 2'd0);
  assign nm1 = bcd_digit({4'b0000, num_q}, 2'd1);
  assign nm0 = bcd_digit({4'b0000, num_q}, 2'd0);

  always_comb begin
    if (state_q == ST_LINE2) begin
      ch = text_char(TXT_L2, idx_q);
      case (idx_q)
        4'd4:                      ch = ascii_digit(nm1);
        4'd5:                      ch = ascii_digit(nm0);
        4'd12, 4'd13, 4'd14, 4'd15: ch = state_char(st_q, idx_q[1:0]);
        default: ;
      endcase
    end else begin
      ch = text_char(TXT_L1, idx_q);
      case (idx_q)
        4'd4:    ch = ascii_digit(lv2);
        4'd5:    ch = ascii_digit(lv1);
        4'd6:    ch = ascii_digit(lv0);
        4'd14:   ch = ascii_digit(tm1);
        4'd15:   ch = ascii_digit(tm0);
        default: ;
      endcase
    end
  end

  assign is_write = !(state_q inside {ST_PWR_WAIT, ST_SNAP, ST_DONE});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    snap_en    = 1'b0;
    frame_done = 1'b0;
    wr_rs      = 1'b0;
    wr_byte    = '0;
    wr_nib     = 1'b0;
    wr_wait    = T_CMD;
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == T_PWR - 1) begin
          cnt_d   = '0;
          state_d = ST_INIT_A;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_INIT_A: begin
        wr_byte = INIT_NIB3;
        wr_nib  = 1'b1;
        wr_wait = T_INIT1;
        if (wr_done) state_d = ST_INIT_B;
      end
      ST_INIT_B: begin
        wr_byte = INIT_NIB3;
        wr_nib  = 1'b1;
        wr_wait = T_INIT2;
        if (wr_done) state_d = ST_INIT_C;
      end
      ST_INIT_C: begin
        wr_byte = INIT_NIB3;
        wr_nib  = 1'b1;
        if (wr_done) state_d = ST_INIT_D;
      end
      ST_INIT_D: begin
        wr_byte = INIT_NIB2;
        wr_nib  = 1'b1;
        if (wr_done) begin
          idx_d   = '0;
          state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        wr_byte = cfg_byte(idx_q[1:0]);
        if (idx_q[1:0] == 2'd3) wr_wait = T_CLR;
        if (wr_done) begin
          if (idx_q == 4'd3) begin
            idx_d   = '0;
            state_d = ST_SNAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_SNAP: begin
        snap_en = 1'b1;
        state_d = ST_ADDR1;
      end
      ST_ADDR1: begin
        wr_byte = LINE1;
        if (wr_done) begin
          idx_d   = '0;
          state_d = ST_LINE1;
        end
      end
      ST_LINE1: begin
        wr_rs   = 1'b1;
        wr_byte = ch;
        if (wr_done) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        wr_byte = LINE2;
        if (wr_done) begin
          idx_d   = '0;
          state_d = ST_LINE2;
        end
      end
      ST_LINE2: begin
        wr_rs   = 1'b1;
        wr_byte = ch;
        if (wr_done) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_SNAP;
      end
      default: state_d = ST_PWR_WAIT;
    endcase
    // One start per write state; pend_q blocks re-issue until the writer reports done.
    wr_start = is_write && !pend_q;
    if (wr_done)       pend_d = 1'b0;
    else if (wr_start) pend_d = 1'b1;
  end

  lcd_byte_writer #(
    .T_EN  (T_EN),
    .T_NIB (T_NIB)
  ) u_writer (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (wr_start),
    .rs_i          (wr_rs),
    .byte_i        (wr_byte),
    .nibble_only_i (wr_nib),
    .wait_cycles_i (wr_wait),
    .done_o        (wr_done),
    .lcd_e_o       (lcd_e),
    .lcd_rs_o      (lcd_rs),
    .lcd_d_o       (wr_d)
  );

  assign lcd_d  = wr_d;
  assign lcd_rw = 1'b0;

endmodule
